load_store_unit: RTL and testbench

Multi-cycle load/store initiator between the core's memory stage and the byte-addressed data RAM. It accepts one request at a time and issues aligned 32-bit word accesses to the RAM. For loads, it extracts and sign- or zero-extends bytes and halfwords. The RAM always writes all four bytes, so byte and halfword stores are performed as a read-modify-write.

---
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store initiator with sub-word read-modify-write stores
// Optional build macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing alignment.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_write_enable,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [15:0] wdata_lo_q;
  logic [31:0] merge_q;
  logic        accept, illegal, misaligned, req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data, store_merge;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_write && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    req_err = illegal || misaligned;
  end

  // Halfword lane uses only addr[1], which also forces H alignment when trapping is off.
  always_comb begin
    lane_b = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h000000, lane_b};
      3'b101:  load_data = {16'h0000, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    store_merge = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      store_merge[{addr_lo_q, 3'b000} +: 8] = wdata_lo_q[7:0];
    else
      store_merge[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                    state_next = RESP;
          else if (!req_write)            state_next = LOAD;
          else if (req_funct3 == 3'b010)  state_next = WRITE;
          else                            state_next = RMW_READ;
        end
      end
      LOAD:     state_next = RESP;
      RMW_READ: state_next = WRITE;
      WRITE:    state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state == IDLE);
    resp_valid       = (state == RESP);
    mem_write_enable = (state == WRITE);
  end

  assign mem_wdata = merge_q;

  // mem_address only moves for requests that will touch the RAM; errors leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      wdata_lo_q  <= 16'h0000;
      merge_q     <= 32'h0;
      resp_rdata  <= 32'h0;
      resp_err    <= 1'b0;
      mem_address <= '0;
    end else begin
      if (accept) begin
        funct3_q   <= req_funct3;
        addr_lo_q  <= req_addr[1:0];
        wdata_lo_q <= req_wdata[15:0];
        resp_rdata <= 32'h0;
        resp_err   <= req_err;
        if (!req_err)
          mem_address <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
        if (req_write && (req_funct3 == 3'b010))
          merge_q <= req_wdata;
      end
      if (state == LOAD)
        resp_rdata <= load_data;
      if (state == RMW_READ)
        merge_q <= store_merge;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a word-level reference
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err, mem_write_enable;
  logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

  logic [31:0] ram [16];
  logic [31:0] ref_mem [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_idx = 4'h0;
  logic [31:0] tb_val = 32'h0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM window covers 0x1000..0x103F; the bench port preloads words while the DUT is idle.
  assign mem_rdata = ram[mem_address[5:2]];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_address[5:2]] <= mem_wdata;
    else if (tb_we)       ram[tb_idx] <= tb_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    tb_we = 1'b1; tb_idx = idx[3:0]; tb_val = val;
    @(posedge clk); #1;
    tb_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] word,
                                output bit err, output logic [31:0] rd,
                                output logic [31:0] nw, output int lat);
    int sh;
    logic [31:0] mask, v;
    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    if (((f3[1:0] == 2'd1) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'd0))) err = 1'b1;
`endif
    rd = 32'h0; nw = word; lat = 1;
    if (err) return;
    case (f3[1:0])
      2'd0:    begin sh = 8 * int'(a[1:0]);  mask = 32'h000000FF; end
      2'd1:    begin sh = 16 * int'(a[1]);   mask = 32'h0000FFFF; end
      default: begin sh = 0;                 mask = 32'hFFFFFFFF; end
    endcase
    if (!wr) begin
      v = (word >> sh) & mask;
      if (!f3[2] && (mask == 32'hFF) && v[7])   v = v | ~mask;
      if (!f3[2] && (mask == 32'hFFFF) && v[15]) v = v | ~mask;
      rd = v; lat = 2;
    end else begin
      nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
      lat = (f3 == 3'd2) ? 2 : 3;
    end
  endfunction

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd_o, output bit err_o);
    bit e_err, seen;
    logic [31:0] e_rd, e_nw;
    int e_lat, idx, writes;
    idx = int'(a[5:2]);
    model(wr, f3, a, wd, ref_mem[idx], e_err, e_rd, e_nw, e_lat);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    writes = 0; seen = 1'b0; rd_o = 32'h0; err_o = 1'b0;
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(negedge clk);
      if (mem_write_enable) writes++;
      if (k == 1 && !e_err) check("mem_address", mem_address, {a[31:2], 2'b00});
      if (resp_valid) begin
        seen = 1'b1;
        check("latency", 32'(k), 32'(e_lat));
        check("resp_err", 32'(resp_err), 32'(e_err));
        check("resp_rdata", resp_rdata, e_rd);
        check("req_ready_resp", 32'(req_ready), 32'd0);
        rd_o = resp_rdata; err_o = resp_err;
      end
    end
    if (!seen) check("resp_timeout", 32'd0, 32'd1);
    check("write_count", 32'(writes), (!e_err && wr) ? 32'd1 : 32'd0);
    ref_mem[idx] = e_nw;
    check("ram_word", ram[idx], e_nw);
  endtask

  initial begin
    logic [31:0] rd;
    bit er;
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    poke(0, 32'h8899AABB);
    do_req(1'b0, 3'b000, 32'h1001, 32'h0, rd, er); check("lb", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'b100, 32'h1001, 32'h0, rd, er); check("lbu", rd, 32'h000000AA);
    do_req(1'b0, 3'b001, 32'h1002, 32'h0, rd, er); check("lh", rd, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h1002, 32'h0, rd, er); check("lhu", rd, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, er); check("lw", rd, 32'h8899AABB);
    poke(0, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h1002, 32'hFFFFFF5A, rd, er); check("sb", ram[0], 32'h115A3344);
    poke(0, 32'h11223344);
    do_req(1'b1, 3'b001, 32'h1000, 32'h0000BEEF, rd, er); check("sh", ram[0], 32'h1122BEEF);
    do_req(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, rd, er); check("sw", ram[0], 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h1002, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", 32'(er), 32'd1);
`else
    check("lw_mis_data", rd, 32'hDEADBEEF);
`endif

    // Store abandoned by reset in the middle of its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h1005; req_wdata = 32'h000000C3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("we_in_write", 32'(mem_write_enable), 32'd1);
    rst_n = 1'b0; #1;
    check("we_after_reset", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    check("no_resp_in_reset", 32'(resp_valid), 32'd0);
    check("ram_untouched", ram[1], ref_mem[1]);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("no_resp_after_reset", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 300; i++)
      do_req(1'($urandom), 3'($urandom), 32'h1000 | ($urandom & 32'h3F), $urandom, rd, er);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
